mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_sequencer.sv | 119 +++++++++++
 tb/tb_mult_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Sequences one MULT through an external multiplier and holds the result in HI/LO.
// Latency: start edge -> LAUNCH (1) -> WAIT (until MultDone) -> MultReady next cycle; StartMult ignored while busy.
module mult_sequencer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StartMult,
  input  logic [31:0] OpA,
  input  logic [31:0] OpB,
  input  logic        MultDone,
  input  logic [31:0] MultHIOut,
  input  logic [31:0] MultLOOut,
  output logic [31:0] RegAOut,
  output logic [31:0] RegBOut,
  output logic        MultCtrl,
  output logic [31:0] HIOut,
  output logic [31:0] LOOut,
  output logic        MultBusy,
  output logic        MultReady,
  output logic        MultError
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_ERROR} state_t;

  localparam logic [6:0] TMO = 7'(TIMEOUT);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] rega_q, rega_d, regb_q, regb_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        ctrl_q, ctrl_d, ready_q, ready_d, err_q, err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ctrl_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 7'd1;
    rega_d  = rega_q;
    regb_d  = regb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    ctrl_d  = ctrl_q;
    ready_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (StartMult) begin
          rega_d  = OpA;
          regb_d  = OpB;
          err_d   = 1'b0;
          ctrl_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_LAUNCH;
        end
      end
      // MultDone here may still be left over from the previous operation.
      S_LAUNCH: begin
        ctrl_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (MultDone) begin
          hi_d    = MultHIOut;
          lo_d    = MultLOOut;
          ctrl_d  = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_inc == TMO) begin
          err_d   = 1'b1;
          ctrl_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        ctrl_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign RegAOut   = rega_q;
  assign RegBOut   = regb_q;
  assign MultCtrl  = ctrl_q;
  assign HIOut     = hi_q;
  assign LOOut     = lo_q;
  assign MultBusy  = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign MultReady = ready_q;
  assign MultError = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: behavioural multiplier fed from RegAOut/RegBOut,
// scoreboard of expected {HI,LO} pushed at each start and popped on MultReady.
module tb_mult_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        StartMult = 1'b0;
  logic [31:0] OpA = '0;
  logic [31:0] OpB = '0;
  logic        MultDone = 1'b0;
  logic [31:0] MultHIOut, MultLOOut;
  logic [31:0] RegAOut, RegBOut, HIOut, LOOut;
  logic        MultCtrl, MultBusy, MultReady, MultError;

  logic        stale = 1'b0;
  longint      pa, pb, pp;
  logic [63:0] sb[$];
  logic [63:0] last_res = '0;
  int          n_assert = 0;
  int          n_fail = 0;

  mult_sequencer #(.TIMEOUT(40)) dut (
    .clock(clock), .reset(reset), .StartMult(StartMult), .OpA(OpA), .OpB(OpB),
    .MultDone(MultDone), .MultHIOut(MultHIOut), .MultLOOut(MultLOOut),
    .RegAOut(RegAOut), .RegBOut(RegBOut), .MultCtrl(MultCtrl),
    .HIOut(HIOut), .LOOut(LOOut), .MultBusy(MultBusy),
    .MultReady(MultReady), .MultError(MultError)
  );

  always #5 clock = ~clock;

  // Stand-in multiplier working on whatever operands the sequencer holds.
  always_comb begin
    pa = longint'($signed(RegAOut));
    pb = longint'($signed(RegBOut));
    pp = pa * pb;
    if (stale) begin
      MultHIOut = 32'hDEADBEEF;
      MultLOOut = 32'hBAADF00D;
    end else begin
      MultHIOut = pp[63:32];
      MultLOOut = pp[31:0];
    end
  end

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rega"},  64'(RegAOut),   64'h0);
    check({tag, "_regb"},  64'(RegBOut),   64'h0);
    check({tag, "_hi"},    64'(HIOut),     64'h0);
    check({tag, "_lo"},    64'(LOOut),     64'h0);
    check({tag, "_ctrl"},  64'(MultCtrl),  64'h0);
    check({tag, "_busy"},  64'(MultBusy),  64'h0);
    check({tag, "_ready"}, 64'(MultReady), 64'h0);
    check({tag, "_err"},   64'(MultError), 64'h0);
  endtask

  // Accepted start; returns in the LAUNCH cycle.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    OpA = a;
    OpB = b;
    StartMult = 1'b1;
    sb.push_back(mul(a, b));
    tick();
    StartMult = 1'b0;
    check("launch_busy", 64'(MultBusy),  64'h1);
    check("launch_ctrl", 64'(MultCtrl),  64'h1);
    check("launch_err",  64'(MultError), 64'h0);
    check("launch_rega", 64'(RegAOut),   64'(a));
    check("launch_regb", 64'(RegBOut),   64'(b));
  endtask

  // Called in a WAIT cycle: asserts MultDone for one edge and checks the capture.
  task automatic finish_op(input string tag);
    logic [63:0] exp;
    MultDone = 1'b1;
    tick();
    MultDone = 1'b0;
    check({tag, "_ready"}, 64'(MultReady), 64'h1);
    check({tag, "_busy"},  64'(MultBusy),  64'h0);
    check({tag, "_ctrl"},  64'(MultCtrl),  64'h0);
    check({tag, "_err"},   64'(MultError), 64'h0);
    if (MultReady && sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_hilo"}, {HIOut, LOOut}, exp);
      last_res = exp;
    end else begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_scoreboard: observed ready=%0d queued=%0d expected ready=1 queued>0",
             tag, MultReady, sb.size());
    end
    tick();
    check({tag, "_ready_drop"}, 64'(MultReady), 64'h0);
  endtask

  initial begin
    #2;
    check_idle_zero("reset");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_idle_zero("post_reset");

    // 7 * -3 with MultDone in WAIT cycle 33
    do_start(32'd7, 32'hFFFF_FFFD);
    tick();
    check("wait1_busy", 64'(MultBusy), 64'h1);
    wait_cycles(32);
    finish_op("basic");
    check("basic_hi", 64'(HIOut), 64'hFFFF_FFFF);
    check("basic_lo", 64'(LOOut), 64'hFFFF_FFEB);

    // stale MultDone with garbage product held through LAUNCH
    do_start(32'd1000, 32'd3000);
    stale = 1'b1;
    MultDone = 1'b1;
    tick();
    MultDone = 1'b0;
    stale = 1'b0;
    check("stale_ready", 64'(MultReady), 64'h0);
    check("stale_busy",  64'(MultBusy),  64'h1);
    check("stale_hilo",  {HIOut, LOOut}, last_res);
    wait_cycles(3);
    finish_op("stale");

    // StartMult while busy is ignored
    do_start(32'd12, 32'hFFFF_FFFC);
    tick();
    wait_cycles(4);
    OpA = 32'd5;
    OpB = 32'd9;
    StartMult = 1'b1;
    tick();
    StartMult = 1'b0;
    check("busy_start_rega", 64'(RegAOut), 64'd12);
    check("busy_start_regb", 64'(RegBOut), 64'hFFFF_FFFC);
    check("busy_start_busy", 64'(MultBusy), 64'h1);
    wait_cycles(2);
    finish_op("busy_start");

    // timeout: no MultDone for 40 WAIT cycles
    do_start(32'd3, 32'd3);
    tick();
    wait_cycles(39);
    check("tmo_w40_busy", 64'(MultBusy),  64'h1);
    check("tmo_w40_err",  64'(MultError), 64'h0);
    tick();
    check("tmo_err",  64'(MultError), 64'h1);
    check("tmo_ctrl", 64'(MultCtrl),  64'h0);
    check("tmo_busy", 64'(MultBusy),  64'h0);
    check("tmo_hilo", {HIOut, LOOut}, last_res);
    sb.delete();
    wait_cycles(2);
    check("tmo_sticky", 64'(MultError), 64'h1);

    // restart from ERROR; MultDone in WAIT cycle 40 wins over the timeout
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    wait_cycles(39);
    finish_op("tmo_edge");

    // asynchronous reset in WAIT cycle 10, late MultDone ignored
    do_start(32'd100, 32'd200);
    tick();
    wait_cycles(9);
    reset = 1'b0;
    #2;
    check_idle_zero("async_reset");
    sb.delete();
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(19);
    MultDone = 1'b1;
    tick();
    MultDone = 1'b0;
    check("late_done_ready", 64'(MultReady), 64'h0);
    check("late_done_hilo",  {HIOut, LOOut}, 64'h0);
    check("late_done_busy",  64'(MultBusy),  64'h0);

    do_start(32'hFFFF_FFFA, 32'd11);
    tick();
    wait_cycles(2);
    finish_op("after_reset");

    check("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
